// File: rtl/queen_search_ctrl.sv
// Backtracking N-queens search engine that drives an external push/pop stack.
// Optional QUEEN_COUNT_ALL_EN: enumerate and count every solution instead of stopping at the first.
module queen_search_ctrl #(
  parameter int unsigned N    = 8,
  parameter int unsigned CW   = 3,
  parameter int unsigned SIZE = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  output logic            stack_push_o,
  output logic            stack_pop_o,
  output logic [SIZE-1:0] stack_data_o,
  input  logic [SIZE-1:0] stack_top_i,
  input  logic            stack_zero_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            found_o,
  output logic            solution_valid_o,
  output logic [15:0]     sol_count_o
);

  localparam int unsigned RW = CW + 1;
  localparam int unsigned IW = CW + 2;
  localparam int unsigned DN = 2 * N - 1;
  localparam logic [CW:0]   LAST_R = RW'(N - 1);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INIT, S_TRY, S_BACKTRACK, S_SOLVED, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW:0]   r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [N-1:0]  col_used_q, col_used_d;
  logic [DN-1:0] d1_used_q, d1_used_d;
  logic [DN-1:0] d2_used_q, d2_used_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
`ifdef QUEEN_COUNT_ALL_EN
  logic [15:0]   sol_count_q, sol_count_d;
`endif

  logic [CW-1:0] top_row, top_col;
  logic [CW:0]   sel_r;
  logic [CW-1:0] sel_c;
  logic [IW-1:0] d1_idx, d2_idx;
  logic [N-1:0]  col_mask;
  logic [DN-1:0] d1_mask, d2_mask;
  logic          safe;

  assign top_row = stack_top_i[2*CW-1:CW];
  assign top_col = stack_top_i[CW-1:0];

  // Occupancy masks for the candidate square, or for the queen being popped while backtracking.
  always_comb begin
    if (state_q == S_BACKTRACK) begin
      sel_r = {1'b0, top_row};
      sel_c = top_col;
    end else begin
      sel_r = r_q;
      sel_c = c_q;
    end
    d1_idx   = IW'(sel_r) + IW'(sel_c);
    d2_idx   = IW'(sel_r) + IW'(N - 1) - IW'(sel_c);
    col_mask = N'(1) << sel_c;
    d1_mask  = DN'(1) << d1_idx;
    d2_mask  = DN'(1) << d2_idx;
    safe     = ~|(col_used_q & col_mask) & ~|(d1_used_q & d1_mask) & ~|(d2_used_q & d2_mask);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      col_used_q  <= '0;
      d1_used_q   <= '0;
      d2_used_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
`ifdef QUEEN_COUNT_ALL_EN
      sol_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      col_used_q  <= col_used_d;
      d1_used_q   <= d1_used_d;
      d2_used_q   <= d2_used_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
`ifdef QUEEN_COUNT_ALL_EN
      sol_count_q <= sol_count_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    col_used_d   = col_used_q;
    d1_used_d    = d1_used_q;
    d2_used_d    = d2_used_q;
    busy_d       = busy_q;
    done_d       = done_q;
    found_d      = found_q;
    stack_push_o = 1'b0;
    stack_pop_o  = 1'b0;
`ifdef QUEEN_COUNT_ALL_EN
    sol_count_d  = sol_count_q;
`endif
    case (state_q)
      S_IDLE: if (start_i) state_d = S_INIT;
      S_DONE: if (start_i) state_d = S_CLEAR;
      S_CLEAR: begin
        if (stack_zero_i) state_d = S_INIT;
        else stack_pop_o = 1'b1;
      end
      S_INIT: begin
        col_used_d = '0;
        d1_used_d  = '0;
        d2_used_d  = '0;
        r_d        = '0;
        c_d        = '0;
        done_d     = 1'b0;
        found_d    = 1'b0;
        busy_d     = 1'b1;
`ifdef QUEEN_COUNT_ALL_EN
        sol_count_d = '0;
`endif
        state_d    = S_TRY;
      end
      S_TRY: begin
        if (safe) begin
          stack_push_o = 1'b1;
          col_used_d   = col_used_q | col_mask;
          d1_used_d    = d1_used_q | d1_mask;
          d2_used_d    = d2_used_q | d2_mask;
          r_d          = r_q + RW'(1);
          c_d          = '0;
          state_d      = (r_q == LAST_R) ? S_SOLVED : S_TRY;
        end else if (c_q != LAST_C) begin
          c_d = c_q + CW'(1);
        end else begin
          state_d = S_BACKTRACK;
        end
      end
      S_BACKTRACK: begin
        if (stack_zero_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef QUEEN_COUNT_ALL_EN
          found_d = (sol_count_q != '0);
`else
          found_d = 1'b0;
`endif
        end else begin
          // Lift the top queen and resume its row at the next column, or keep unwinding.
          stack_pop_o = 1'b1;
          col_used_d  = col_used_q & ~col_mask;
          d1_used_d   = d1_used_q & ~d1_mask;
          d2_used_d   = d2_used_q & ~d2_mask;
          r_d         = {1'b0, top_row};
          if (top_col != LAST_C) begin
            c_d     = top_col + CW'(1);
            state_d = S_TRY;
          end
        end
      end
      S_SOLVED: begin
`ifdef QUEEN_COUNT_ALL_EN
        if (sol_count_q != 16'hFFFF) sol_count_d = sol_count_q + 16'd1;
        state_d = S_BACKTRACK;
`else
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        found_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stack_data_o = SIZE'({r_q[CW-1:0], c_q});
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign found_o      = found_q;
`ifdef QUEEN_COUNT_ALL_EN
  assign solution_valid_o = (state_q == S_SOLVED);
  assign sol_count_o      = sol_count_q;
`else
  assign solution_valid_o = 1'b0;
  assign sol_count_o      = '0;
`endif

endmodule
